icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Direct-mapped instruction cache sitting directly upstream of the fetch stage.
- Accepts a byte PC from fetch and returns a full BLOCK_SIZE-bit line. The first instruction of the line occupies the top 32 bits, so fetch indexes it from bit BLOCK_SIZE-32 downward.
- On a miss it raises miss and refills the line from the memory port, one 32-bit word per beat, then installs the line and delivers it.

Parameters:
- WORD_SIZE, 32, instruction/memory word width in bits.
- BLOCK_SIZE, 1024, line width in bits (128 bytes, 32 words).
- NUM_LINES, 16, number of cache lines; power of two.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch presents req_addr.
- req_addr  in  ADDR_W  byte PC; low 7 bits ignored (line-aligned internally).
- req_ready  out  1  cache can accept a request.
- flush  in  1  invalidate all lines.
- line_valid  out  1  one-cycle pulse; line_data valid.
- line_data  out  BLOCK_SIZE  returned line, held until the next response.
- miss  out  1  high while a refill is outstanding.
- mem_req  out  1  refill request, level.
- mem_addr  out  ADDR_W  line-aligned refill address.
- mem_rvalid  in  1  one refill word this cycle.
- mem_rdata  in  WORD_SIZE  refill word.

Behaviour:
- Address split: offset = req_addr[6:0], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Storage per line: valid bit, tag, data.
- Reset values (asynchronous): all valid bits 0, state IDLE, req_ready 1, line_valid 0, line_data 0, miss 0, mem_req 0, mem_addr 0, beat counter 0.
- IDLE
  - req_ready=1.
  - On req_valid: latch the line-aligned address, go to LOOKUP. req_ready drops the next cycle.
- LOOKUP (1 cycle)
  - Hit (valid and tag equal): load line_data from the array, pulse line_valid next cycle, return to IDLE. Hit latency: request cycle + 2 edges to line_valid.
  - Miss: go to REFILL; set miss=1, mem_req=1, mem_addr=latched aligned address, beat counter=0.
- REFILL
  - Each cycle with mem_rvalid=1, write mem_rdata to fill-buffer bits [BLOCK_SIZE-1-WORD_SIZE*k -: WORD_SIZE] and increment k.
  - Beats may have gaps of any length. Words arrive in ascending address order.
  - mem_rvalid outside REFILL is ignored.
  - On beat k=31: drop mem_req and miss on the next edge, go to INSTALL.
- INSTALL (1 cycle)
  - Write fill buffer, tag and valid=1 into the indexed line.
  - Drive line_data=fill buffer, pulse line_valid, return to IDLE.
- Miss latency: 1 (LOOKUP) + 32 beats + 1 (INSTALL).
- Flush
  - In IDLE/LOOKUP: clears all valid bits that cycle. A LOOKUP in the same cycle is treated as a miss.
  - During REFILL: clears valid bits. The refill still completes and delivers line_valid, but INSTALL does not set valid for that line.
  - flush together with req_valid in IDLE: flush wins; the request is accepted and will miss.
- Conflicts: a line replaced by a refill to the same index with a different tag loses its old contents (direct-mapped eviction).
- Reset mid-refill: refill abandoned immediately, mem_req=0, all lines invalid. Further mem_rvalid beats are ignored.
- Requests while req_ready=0 are ignored; fetch must hold req_valid until accepted.

Optional Feature:
- Macro ICACHE_STATS_EN.
- With the macro: adds outputs hit_count and miss_count, 32 bits each, reset to 0, saturating at all-ones.
  - hit_count increments once per LOOKUP hit; miss_count once per LOOKUP miss.
  - flush does not clear them.
- Without the macro: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, req_addr=0x0000_0080, memory returns words 0x0..0x1F.
  - Required: miss high for the refill.
  - Required: mem_addr=0x80.
  - Required: line_valid once, with line_data[1023:992]=0x0 and line_data[31:0]=0x1F.
- Hit: repeat req_addr=0x0000_00C4 after the above.
  - Required: no mem_req; line_valid 2 edges after acceptance, same line_data.
- Conflict eviction (NUM_LINES=16): req 0x080 then 0x880, both same index.
  - Required: second request misses with mem_addr=0x880.
  - Required: re-request 0x080 misses again.
- Beat gaps: insert 3 idle cycles between every mem_rvalid.
  - Required: line assembled correctly; miss deasserts only after beat 31.
- Flush mid-refill: assert flush at beat 10.
  - Required: the line is still delivered.
  - Required: an immediate re-request to the same address misses.
- Reset mid-refill: rst_n low at beat 5.
  - Required: mem_req=0 and req_ready=1 at once; the next request to that address misses.
  - With ICACHE_STATS_EN: counters read 0 after reset.

Source files
------------

// File: rtl/icache_refill.sv
// Direct-mapped instruction cache returning whole lines, refilled one word per beat.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_refill #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 1024,
  parameter int NUM_LINES  = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  line_valid,
  output logic [BLOCK_SIZE-1:0] line_data,
  output logic                  miss,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_rvalid,
  input  logic [WORD_SIZE-1:0]  mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int BEATS  = BLOCK_SIZE / WORD_SIZE;
  localparam int OFF_W  = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, INSTALL} state_t;
  state_t state, state_nxt;

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_arr  [NUM_LINES];
  logic [BLOCK_SIZE-1:0] data_arr [NUM_LINES];
  logic [WORD_SIZE-1:0]  fill_w   [BEATS];
  logic [BLOCK_SIZE-1:0] fill_line;
  logic [LINE_W-1:0]     line_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  flushed_q;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  last_beat;
  logic                  unused_ok;

  assign idx       = line_q[IDX_W-1:0];
  assign tag       = line_q[LINE_W-1:IDX_W];
  // A flush in the lookup cycle forces a miss even if the line was valid.
  assign hit       = valid_q[idx] && (tag_arr[idx] == tag) && !flush;
  assign last_beat = mem_rvalid && (beat_q == BEAT_W'(BEATS - 1));
  assign req_ready = (state == IDLE);
  assign unused_ok = ^req_addr[OFF_W-1:0];

  // First word received lands in the top bits of the line.
  always_comb begin
    fill_line = '0;
    for (int k = 0; k < BEATS; k++) begin
      fill_line[BLOCK_SIZE-1-WORD_SIZE*k -: WORD_SIZE] = fill_w[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit ? IDLE : REFILL;
      REFILL:  if (last_beat) state_nxt = INSTALL;
      INSTALL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      line_valid <= 1'b0;
      line_data  <= '0;
      miss       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      beat_q     <= '0;
      flushed_q  <= 1'b0;
    end else begin
      line_valid <= 1'b0;
      if (flush) valid_q <= '0;
      case (state)
        LOOKUP: begin
          if (hit) begin
            line_valid <= 1'b1;
            line_data  <= data_arr[idx];
          end else begin
            miss      <= 1'b1;
            mem_req   <= 1'b1;
            mem_addr  <= {line_q, {OFF_W{1'b0}}};
            beat_q    <= '0;
            flushed_q <= 1'b0;
          end
        end
        REFILL: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              miss    <= 1'b0;
              mem_req <= 1'b0;
            end
          end
        end
        INSTALL: begin
          line_valid <= 1'b1;
          line_data  <= fill_line;
          // A flush seen during the refill delivers the line but leaves it invalid.
          if (!flush && !flushed_q) valid_q[idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) line_q <= req_addr[ADDR_W-1:OFF_W];
    if (state == REFILL && mem_rvalid) fill_w[beat_q] <= mem_rdata;
    if (state == INSTALL) begin
      data_arr[idx] <= fill_line;
      tag_arr[idx]  <= tag;
    end
  end

`ifdef ICACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_count  <= sat_inc(hit_count);
      else     miss_count <= sat_inc(miss_count);
    end
  end
`else
  // Default build carries no statistics counters.
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill against a line-level cache model.
module tb_icache_refill;
  localparam int WS = 32;
  localparam int BS = 1024;
  localparam int NL = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          flush = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [WS-1:0] mem_rdata = '0;
  logic          req_ready, line_valid, miss, mem_req;
  logic [BS-1:0] line_data;
  logic [AW-1:0] mem_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_count, miss_count;
`endif

  icache_refill dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .line_valid(line_valid),
    .line_data(line_data), .miss(miss), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 0;

  logic          exp_req_ready = 1'b1, exp_miss = 1'b0, exp_mem_req = 1'b0, exp_line_valid = 1'b0;
  logic [AW-1:0] exp_mem_addr = '0;
  logic [BS-1:0] exp_line_data = '0;
  logic [31:0]   exp_hits = 0, exp_misses = 0;

  bit            mvalid [NL];
  logic [31:0]   mtag   [NL];
  logic [BS-1:0] mdata  [NL];

  bit            miss_seen, mem_req_seen;
  int            lv_count = 0, lv_start;
  logic [AW-1:0] cap_mem_addr;
  logic [BS-1:0] cap_line;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a, input int k);
    return ((((a >> 7) - 32'd1)) << 16) + 32'(k);
  endfunction

  function automatic logic [BS-1:0] mkline(input logic [31:0] a);
    logic [BS-1:0] l;
    l = '0;
    for (int k = 0; k < BS / WS; k++) l[BS-1-WS*k -: WS] = memword(a, k);
    return l;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NL; i++) mvalid[i] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, exp_req_ready);
      chk("miss", miss, exp_miss);
      chk("mem_req", mem_req, exp_mem_req);
      chk("line_valid", line_valid, exp_line_valid);
      chk("mem_addr", mem_addr, exp_mem_addr);
      n_checks++;
      if (line_data !== exp_line_data) begin
        n_err++;
        for (int w = 0; w < BS / WS; w++) begin
          if (line_data[BS-1-WS*w -: WS] !== exp_line_data[BS-1-WS*w -: WS]) begin
            $display("FAIL line_data word %0d: got %h expected %h", w,
                     line_data[BS-1-WS*w -: WS], exp_line_data[BS-1-WS*w -: WS]);
            break;
          end
        end
      end
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, exp_hits);
      chk("miss_count", miss_count, exp_misses);
`endif
      if (miss) miss_seen = 1;
      if (mem_req) begin
        mem_req_seen = 1;
        cap_mem_addr = mem_addr;
      end
      if (line_valid) begin
        lv_count++;
        cap_line = line_data;
      end
    end
  end

  task automatic reset_mid();
    req_valid = 0;
    rst_n = 0;
    #1;
    exp_miss = 0; exp_mem_req = 0; exp_mem_addr = '0; exp_req_ready = 1;
    exp_line_valid = 0; exp_line_data = '0; exp_hits = 0; exp_misses = 0;
    clear_model();
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    mem_rvalid = 1;
    mem_rdata = $urandom;
    tick();
    tick();
    rst_n = 1;
    repeat (3) begin
      mem_rdata = $urandom;
      tick();
    end
    mem_rvalid = 0;
  endtask

  task automatic do_req(input logic [31:0] addr, input int gap, input int flush_at,
                        input int rst_at, input bit fwr, input bit rnd_gap);
    logic [31:0] al, tg;
    int id, g;
    bit hit, flushed;
    al = addr & ~32'h7F;
    id = int'((addr >> 7) & 32'hF);
    tg = addr >> 11;
    miss_seen = 0;
    mem_req_seen = 0;
    lv_start = lv_count;
    req_valid = 1; req_addr = addr; flush = fwr;
    tick();
    req_valid = 0; req_addr = $urandom; flush = 0; exp_req_ready = 0;
    if (fwr) clear_model();
    hit = mvalid[id] && (mtag[id] == tg);
    tick();
    if (hit) begin
      exp_hits++;
      exp_line_valid = 1; exp_line_data = mdata[id]; exp_req_ready = 1;
      tick();
      exp_line_valid = 0;
      return;
    end
    exp_misses++;
    exp_miss = 1; exp_mem_req = 1; exp_mem_addr = al;
    flushed = 0;
    for (int k = 0; k < BS / WS; k++) begin
      g = rnd_gap ? $urandom_range(0, 3) : gap;
      repeat (g) begin
        mem_rvalid = 0; mem_rdata = $urandom;
        req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom;
        tick();
      end
      if (k == rst_at) begin
        reset_mid();
        return;
      end
      mem_rvalid = 1; mem_rdata = memword(al, k);
      req_valid = (k != BS / WS - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_addr = $urandom;
      flush = (k == flush_at);
      if (flush) begin
        flushed = 1;
        clear_model();
      end
      tick();
    end
    mem_rvalid = 0; flush = 0; req_valid = 0;
    exp_miss = 0; exp_mem_req = 0;
    tick();
    exp_line_valid = 1; exp_line_data = mkline(al); exp_req_ready = 1;
    if (!flushed) begin
      mvalid[id] = 1; mtag[id] = tg; mdata[id] = exp_line_data;
    end
    tick();
    exp_line_valid = 0;
  endtask

  logic [31:0] pool [6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    pool[0] = 32'h80; pool[1] = 32'h880; pool[2] = 32'h1100;
    pool[3] = 32'h2180; pool[4] = 32'h300; pool[5] = 32'h1080;
    tick();
    tick();
    chk("reset_req_ready", req_ready, 1);
    chk("reset_miss", miss, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_line_valid", line_valid, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_line_data_zero", line_data == '0, 1);
    rst_n = 1;
    chk_en = 1;
    tick();

    do_req(32'h80, 0, -1, -1, 0, 0);
    chk("cold_miss_seen", miss_seen, 1);
    chk("cold_mem_addr", cap_mem_addr, 32'h80);
    chk("cold_lv_once", lv_count - lv_start, 1);
    chk("cold_top_word", cap_line[1023:992], 32'h0);
    chk("cold_bottom_word", cap_line[31:0], 32'h1F);

    do_req(32'hC4, 0, -1, -1, 0, 0);
    chk("hit_no_mem_req", mem_req_seen, 0);
    chk("hit_lv_once", lv_count - lv_start, 1);
    chk("hit_bottom_word", cap_line[31:0], 32'h1F);

    do_req(32'h880, 0, -1, -1, 0, 0);
    chk("conflict_miss", miss_seen, 1);
    chk("conflict_mem_addr", cap_mem_addr, 32'h880);
    chk("conflict_bottom_word", cap_line[31:0], 32'h0010_001F);
    do_req(32'h80, 0, -1, -1, 0, 0);
    chk("evicted_miss", miss_seen, 1);
    chk("evicted_mem_addr", cap_mem_addr, 32'h80);

    do_req(32'h1100, 3, -1, -1, 0, 0);
    chk("gap_top_word", cap_line[1023:992], 32'h0021_0000);
    chk("gap_word5", cap_line[1023-32*5 -: 32], 32'h0021_0005);

    do_req(32'h2180, 1, 10, -1, 0, 0);
    chk("flush_mid_lv_once", lv_count - lv_start, 1);
    chk("flush_mid_top_word", cap_line[1023:992], 32'h0042_0000);
    do_req(32'h2180, 0, -1, -1, 0, 0);
    chk("flush_rereq_miss", miss_seen, 1);

    do_req(32'h300, 0, -1, 5, 0, 0);
    chk("rst_mid_no_lv", lv_count - lv_start, 0);
    do_req(32'h300, 0, -1, -1, 0, 0);
    chk("rst_rereq_miss", miss_seen, 1);
    do_req(32'h300, 0, -1, -1, 1, 0);
    chk("flush_with_req_miss", miss_seen, 1);

    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        flush = 1;
        tick();
        flush = 0;
        clear_model();
      end
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      tick();
      mem_rvalid = 0;
      do_req(pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 127)), 0,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1,
             -1, 0, 1);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
